imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Hardware program loader for riscv_pipelined_core: the in-silicon writer side of instruction-memory initialisation.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each word sequentially into instruction memory through a dedicated write port.
- Holds the core in reset until the whole program is loaded, then releases it.

Parameters:
- XLEN, 32, instruction/data word width in bits.
- IMEM_DEPTH, 256, number of words in instruction memory.
- ADDR_W, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_data  input  8  incoming stream byte.
- byte_valid  input  1  byte_data valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when valid && ready.
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  XLEN  word being written.
- core_reset  output  1  reset to the core; high while loading.
- load_done  output  1  program loaded; core running.
- load_err  output  1  load aborted; core held in reset.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_err=0, byte_ready=0, word count=0, byte index=0.
- FSM states: HDR_LO, HDR_HI, DATA, (CKSUM), DONE, ERROR. The FSM enters HDR_LO on reset release.
- Stream format: 16-bit word count N, low byte first, followed by N words, each little-endian (byte 0 goes to bits [7:0]).
- byte_ready is 1 in HDR_LO, HDR_HI, DATA and CKSUM, and 0 in DONE and ERROR. No backpressure occurs while loading.
- HDR_LO: accepting a byte latches N[7:0] and moves to HDR_HI.
- HDR_HI: accepting a byte latches N[15:8], then:
  - N==0 -> DONE (or CKSUM if enabled).
  - N>IMEM_DEPTH -> ERROR.
  - otherwise -> DATA with write address 0.
- DATA:
  - A 2-bit byte index shifts each accepted byte into an assembly register.
  - On acceptance of the 4th byte, the next cycle drives imem_we=1 with the current address and the assembled word. The address then increments.
  - imem_we is registered, so there is 1 cycle of latency from the 4th byte to the write.
  - After word N-1 is accepted -> DONE (or CKSUM).
  - The address never wraps, because N<=IMEM_DEPTH is guaranteed.
- Cycles with byte_valid=0 do not advance state. Partial words are held indefinitely.
- DONE:
  - core_reset=0 and load_done=1, both registered, asserted the cycle after entry.
  - core_reset deasserts on the same edge that performs the final imem write, so the last write lands before the core's first fetch.
- ERROR: load_err=1 and core_reset=1. Held until reload or reset.
- reload (honoured only in DONE or ERROR):
  - Next state is HDR_LO; core_reset=1, load_done=0, load_err=0.
  - Byte index and address are cleared.
  - Memory contents are not cleared.
- reload in any other state is ignored.
- A byte presented in the same cycle as reload is not accepted, because byte_ready=0 that cycle.
- Reset asserted mid-load aborts asynchronously to reset values. The partially written imem keeps its content.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - The stream carries one trailing byte after the last data word (or after the header when N==0).
  - A running XOR covers all data bytes, excluding header bytes.
  - In CKSUM, the accepted byte is compared with the running XOR: equal -> DONE; mismatch -> ERROR.
  - The XOR clears on reset and on reload.
- When undefined: there is no CKSUM state or XOR logic, and DATA/HDR_HI go directly to DONE.

Test Plan:
- Load N=2 (bytes 02 00 13 05 10 00 93 05 F0 FF) -> imem[0]=0x00100513 and imem[1]=0xFFF00593. Each imem_we is one cycle after the 4th byte. core_reset falls with the second write; load_done=1.
- Header 00 00 -> DONE with no imem_we pulses; core_reset=0 two cycles after the second header byte.
- Header 01 01 (N=257 > 256) -> ERROR, load_err=1, core_reset stays 1, byte_ready=0, no writes.
- Random gaps on byte_valid during a 3-word load, plus reset asserted after byte 5 -> outputs return to reset values immediately. A fresh load of 1 word 0xDEADBEEF then writes imem[0]=0xDEADBEEF.
- After DONE, pulse reload and send a new 1-word program 0x00000013 -> core_reset rises within 1 cycle, imem[0] updated, load_done returns to 1.
- LOADER_CHECKSUM_EN: N=1 word 0x11223344 with checksum 0x44 -> DONE. The same stream with checksum 0x45 -> ERROR, load_err=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Hardware program loader for riscv_pipelined_core. Takes a byte
//            stream (valid/ready), assembles little-endian XLEN-bit words and
//            writes them sequentially into instruction memory, holding the
//            core in reset until the whole program has landed.
//
// Stream   : N[7:0], N[15:8], then N words (byte 0 -> bits [7:0]),
//            plus one trailing XOR checksum byte when LOADER_CHECKSUM_EN.
//
// Ports    : clk          system clock (rising edge)
//            reset        asynchronous active-high reset
//            byte_data    incoming stream byte
//            byte_valid   byte_data valid this cycle
//            byte_ready   loader can accept a byte (registered)
//            reload       single-cycle pulse, restarts from DONE/ERROR
//            imem_we      one-cycle write strobe per assembled word
//            imem_addr    word address of the write
//            imem_wdata   word being written
//            core_reset   held high until the program is loaded
//            load_done    program loaded, core running
//            load_err     load aborted, core held in reset
//
// Options  : `define LOADER_CHECKSUM_EN adds the CKSUM state and a running
//            XOR over all data bytes (header bytes excluded).
//
// Revision : 1.0  initial release
// ============================================================================
module imem_boot_loader #(
  parameter int XLEN       = 32,  // multiple of 8, at least 24
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int                BPW       = XLEN / 8;
  localparam int                BIDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CKSUM  = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t            state_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;       // address presented with the write strobe
  logic [XLEN-1:0]   wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        n_lo_q;       // header low byte, waiting for the high byte
  logic [15:0]       rem_q;        // words still to be received
  logic [ADDR_W-1:0] waddr_q;      // address the next assembled word goes to
  logic [BIDX_W-1:0] bidx_q;       // byte position inside the current word
  logic [XLEN-9:0]   asm_q;        // bytes 0..BPW-2 of the current word
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        accept;
  logic [15:0] hdr_n;

  assign accept = byte_valid & ready_q;
  assign hdr_n  = {byte_data, n_lo_q};

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HDR_LO;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      n_lo_q     <= '0;
      rem_q      <= '0;
      waddr_q    <= '0;
      bidx_q     <= '0;
      asm_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_HDR_LO: begin
          // ready comes up here on the first cycle after reset release
          ready_q <= 1'b1;
          if (accept) begin
            n_lo_q  <= byte_data;
            state_q <= ST_HDR_HI;
          end
        end

        ST_HDR_HI: begin
          if (accept) begin
            if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CKSUM;
`else
              state_q <= ST_DONE;
              ready_q <= 1'b0;
`endif
            end else if ({1'b0, hdr_n} > MAX_WORDS) begin
              state_q <= ST_ERROR;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_DATA;
              rem_q   <= hdr_n;
              waddr_q <= '0;
              bidx_q  <= '0;
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_data;
`endif
            if (bidx_q == LAST_BYTE) begin
              // last byte completes the word: strobe it out next cycle
              bidx_q  <= '0;
              we_q    <= 1'b1;
              addr_q  <= waddr_q;
              wdata_q <= {byte_data, asm_q};
              waddr_q <= waddr_q + 1'b1;
              rem_q   <= rem_q - 16'd1;
              if (rem_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= ST_CKSUM;
`else
                state_q <= ST_DONE;
                ready_q <= 1'b0;
`endif
              end
            end else begin
              bidx_q <= bidx_q + 1'b1;
              asm_q  <= {byte_data, asm_q[XLEN-9:8]};
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CKSUM: begin
          if (accept) begin
            ready_q <= 1'b0;
            state_q <= (byte_data == xor_q) ? ST_DONE : ST_ERROR;
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (reload) begin
            state_q    <= ST_HDR_LO;
            ready_q    <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bidx_q     <= '0;
            waddr_q    <= '0;
            addr_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
          end else if (state_q == ST_DONE) begin
            // one cycle after entry, which is also the edge that commits
            // the final write, so memory is complete before the first fetch
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            core_rst_q <= 1'b1;
            err_q      <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_HDR_LO;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader. Builds byte streams
//            from word lists, keeps a behavioural image of what memory must
//            hold and when each write / status change must appear, and
//            compares against a memory written through the DUT write port.
//            Honours LOADER_CHECKSUM_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int XLEN       = 32;
  localparam int IMEM_DEPTH = 256;
  localparam int ADDR_W     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_err;

  imem_boot_loader #(
    .XLEN       (XLEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory fed by the DUT write port, plus a log of writes
  logic [XLEN-1:0] mem [IMEM_DEPTH];
  int unsigned     wr_cyc[$];
  int unsigned     wr_addr[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(32'(imem_addr));
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one byte after a random idle gap; returns the negedge cycle at
  // which the byte was presented with ready high (accepted on the next edge).
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise,
                           output int unsigned acc_cyc);
    int g;
    int waitc;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      reload     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    @(negedge clk);
    reload     = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    waitc      = 0;
    while (byte_ready !== 1'b1 && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    check("byte_ready_wait", byte_ready, 1);
    acc_cyc = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    imem_we,    0);
    check({tag, "_addr"},  imem_addr,  0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_crst"},  core_reset, 1);
    check({tag, "_done"},  load_done,  0);
    check({tag, "_err"},   load_err,   0);
    check({tag, "_ready"}, byte_ready, 0);
  endtask

  // Pulse reload from DONE/ERROR with a byte offered in the same cycle,
  // which must be ignored.
  task automatic pulse_reload();
    @(negedge clk);
    reload     = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    @(negedge clk);
    reload     = 1'b0;
    byte_valid = 1'b0;
    check("reload_crst",  core_reset, 1);
    check("reload_done",  load_done,  0);
    check("reload_err",   load_err,   0);
    check("reload_ready", byte_ready, 1);
  endtask

  // Status two cycles after the header that must be rejected
  task automatic expect_error(input int wr0);
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    check("err_flag",   load_err,   1);
    check("err_crst",   core_reset, 1);
    check("err_ready",  byte_ready, 0);
    check("err_done",   load_done,  0);
    check("err_writes", wr_cyc.size() - wr0, 0);
  endtask

  // Stream exp_words as a program and check writes, timing and status.
  task automatic load_program(input int max_gap, input bit noise, input bit bad_cks);
    int          n;
    int          wr0;
    logic [15:0] nn;
    logic [7:0]  x;
    logic [31:0] w;
    int unsigned acc;
    int unsigned acc4[$];
    bit          ok;
    n   = exp_words.size();
    nn  = 16'(n);
    x   = 8'h00;
    wr0 = wr_cyc.size();
    ok  = 1'b1;
    send_byte(nn[7:0],  max_gap, noise, acc);
    send_byte(nn[15:8], max_gap, noise, acc);
    for (int i = 0; i < n; i++) begin
      w = exp_words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], max_gap, noise, acc);
        x = x ^ w[8*b +: 8];
      end
      acc4.push_back(acc);
    end
`ifdef LOADER_CHECKSUM_EN
    ok = !bad_cks;
    send_byte(bad_cks ? ~x : x, max_gap, noise, acc);
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    reload     = 1'b0;
    check("crst_before_end", core_reset, 1);
    @(negedge clk);
    if (ok) begin
      check("done_crst",  core_reset, 0);
      check("done_flag",  load_done,  1);
      check("done_err",   load_err,   0);
      check("done_ready", byte_ready, 0);
    end else begin
      check("cks_err_flag",  load_err,   1);
      check("cks_err_crst",  core_reset, 1);
      check("cks_err_done",  load_done,  0);
      check("cks_err_ready", byte_ready, 0);
    end
    check("write_count", wr_cyc.size() - wr0, n);
    if (wr_cyc.size() >= wr0 + n) begin
      for (int i = 0; i < n; i++) begin
        check("write_addr",  wr_addr[wr0 + i], i);
        check("write_cycle", wr_cyc[wr0 + i],  acc4[i] + 1);
        check("mem_word",    mem[i],           exp_words[i]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          wr0;
    int unsigned acc;
    logic [15:0] big;
    logic [7:0]  part[$];

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reload     = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    // Two-word program: 02 00 13 05 10 00 93 05 F0 FF
    exp_words = '{32'h00100513, 32'hFFF00593};
    load_program(0, 1'b0, 1'b0);

    // Empty program goes straight to DONE without writes
    pulse_reload();
    exp_words = {};
    load_program(0, 1'b0, 1'b0);

    // N = 257 exceeds memory depth
    pulse_reload();
    wr0 = wr_cyc.size();
    send_byte(8'h01, 0, 1'b0, acc);
    send_byte(8'h01, 0, 1'b0, acc);
    expect_error(wr0);

    // Gapped 3-word load aborted by reset after the fifth stream byte
    pulse_reload();
    part = '{8'h03, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom)};
    for (int i = 0; i < 5; i++) send_byte(part[i], 3, 1'b0, acc);
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b1;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_words = '{32'hDEADBEEF};
    load_program(2, 1'b0, 1'b0);

    // Reload after DONE with a new one-word program
    pulse_reload();
    exp_words = '{32'h00000013};
    load_program(0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    pulse_reload();
    exp_words = '{32'h11223344};
    load_program(0, 1'b0, 1'b0);
    pulse_reload();
    load_program(0, 1'b0, 1'b1);
`endif

    // Randomized programs with gaps and ignored reload pulses mid-load
    for (int it = 0; it < 6; it++) begin
      pulse_reload();
      exp_words = {};
      for (int i = 0; i < int'($urandom_range(8, 1)); i++) exp_words.push_back($urandom);
      load_program(3, 1'b1, 1'($urandom_range(1, 0)));
    end

    // Random oversize header
    pulse_reload();
    big = 16'($urandom_range(65535, 257));
    wr0 = wr_cyc.size();
    send_byte(big[7:0],  2, 1'b0, acc);
    send_byte(big[15:8], 2, 1'b0, acc);
    expect_error(wr0);

    // Full-depth boundary: N == IMEM_DEPTH is accepted
    pulse_reload();
    exp_words = {};
    for (int i = 0; i < IMEM_DEPTH; i++) exp_words.push_back($urandom);
    load_program(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
